// File: rtl/hps_design_pll_reset_pkg.sv
// Shared definitions for the HPS-design PLL reset sequencer.
//   state_e  : FSM state encoding, also exported on state_dbg
//   sat_inc  : saturating increment for counters of arbitrary width (up to 32 bits)
package hps_design_pll_reset_pkg;

  typedef enum logic [2:0] {
    StPllReset = 3'd0,
    StWaitLock = 3'd1,
    StLockQual = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4
  } state_e;

  // Returns val+1, or val unchanged once it has reached 2^width-1.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/hps_design_sync2.sv
// Two-flop synchroniser for a single asynchronous level signal.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronised output, two clk edges of latency
module hps_design_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hps_design_pll_reset_seq.sv
// Reset sequencer downstream of the HPS-design PLL, clocked by the free-running reference.
// Resets the PLL, waits for lock (retrying on timeout), qualifies lock stability, then
// releases per-domain resets one stage at a time. Lock loss re-asserts every stage at once.
//   refclk          : reference clock, all logic on its rising edge
//   rst             : synchronous active-high reset
//   pll_locked      : PLL lock indicator, asynchronous to refclk
//   pll_rst         : reset to the PLL, active-high
//   rst_out         : per-stage resets, active-high, cleared in ascending index order
//   ready           : all stages released and the sequencer is running
//   lock_loss_count : saturating count of lock losses after release began
//   retry_count     : saturating count of lock timeouts
//   state_dbg       : current FSM state encoding
module hps_design_pll_reset_seq
  import hps_design_pll_reset_pkg::*;
#(
  parameter int unsigned NUM_STAGES          = 3,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned STAGE_GAP_CYCLES    = 8,
  parameter int unsigned CNT_W               = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [CNT_W-1:0]      lock_loss_count,
  output logic [CNT_W-1:0]      retry_count,
  output logic [2:0]            state_dbg
);

  // One timer serves both PLL_RESET and WAIT_LOCK, so it is sized for the larger of the two.
  localparam int unsigned TimerMax = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;
  localparam int unsigned QualW    = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned GapW     = (STAGE_GAP_CYCLES > 1) ? $clog2(STAGE_GAP_CYCLES) : 1;

  localparam logic [TimerW-1:0] RstLast     = TimerW'(PLL_RST_CYCLES - 1);
  localparam logic [TimerW-1:0] TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [QualW-1:0]  QualLast    = QualW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GapW-1:0]   GapLast     = GapW'(STAGE_GAP_CYCLES - 1);

  state_e                  state_q;
  logic                    pll_rst_q;
  logic [NUM_STAGES-1:0]   rst_out_q;
  logic                    ready_q;
  logic [TimerW-1:0]       timer_q;
  logic [QualW-1:0]        qual_q;
  logic [GapW-1:0]         gap_q;
  logic [CNT_W-1:0]        lock_loss_q;
  logic [CNT_W-1:0]        retry_q;
  logic                    lk;

  hps_design_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= StPllReset;
      pll_rst_q   <= 1'b1;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      timer_q     <= '0;
      qual_q      <= '0;
      gap_q       <= '0;
      lock_loss_q <= '0;
      retry_q     <= '0;
    end else begin
      case (state_q)
        StPllReset: begin
          if (timer_q == RstLast) begin
            state_q   <= StWaitLock;
            timer_q   <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StWaitLock: begin
          if (lk) begin
            state_q <= StLockQual;
            qual_q  <= '0;
          end else if (timer_q == TimeoutLast) begin
            state_q   <= StPllReset;
            timer_q   <= '0;
            pll_rst_q <= 1'b1;
            retry_q   <= CNT_W'(sat_inc(32'(retry_q), CNT_W));
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StLockQual: begin
          // Loss is tested first so a drop on the qualifying cycle still restarts.
          if (!lk) begin
            state_q <= StWaitLock;
            timer_q <= '0;
          end else if (qual_q == QualLast) begin
            state_q   <= StRelease;
            gap_q     <= '0;
            rst_out_q <= rst_out_q << 1;
          end else begin
            qual_q <= qual_q + QualW'(1);
          end
        end

        StRelease: begin
          if (!lk) begin
            state_q     <= StWaitLock;
            timer_q     <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_loss_q <= CNT_W'(sat_inc(32'(lock_loss_q), CNT_W));
          end else if (rst_out_q == '0) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else if (gap_q == GapLast) begin
            // Shifting a zero in from the bottom keeps the release order monotonic.
            rst_out_q <= rst_out_q << 1;
            gap_q     <= '0;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end

        StRun: begin
          if (!lk) begin
            state_q     <= StWaitLock;
            timer_q     <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_loss_q <= CNT_W'(sat_inc(32'(lock_loss_q), CNT_W));
          end
        end

        default: begin
          state_q   <= StPllReset;
          timer_q   <= '0;
          pll_rst_q <= 1'b1;
          rst_out_q <= '1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst         = pll_rst_q;
  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign lock_loss_count = lock_loss_q;
  assign retry_count     = retry_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_hps_design_pll_reset_seq.sv
// Self-checking bench for hps_design_pll_reset_seq. A timeline model (phase plus the cycle
// it was entered) predicts every output each cycle; directed scenarios add latency checks.
module tb_hps_design_pll_reset_seq;

  localparam int NS  = 3;
  localparam int PRC = 4;
  localparam int LTC = 32;
  localparam int LSC = 8;
  localparam int GAP = 2;
  localparam int CW  = 2;
  localparam int CntMax = (1 << CW) - 1;

  localparam int MPllReset = 0;
  localparam int MWaitLock = 1;
  localparam int MLockQual = 2;
  localparam int MRelease  = 3;
  localparam int MRun      = 4;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic [NS-1:0] rst_out;
  logic          ready;
  logic [CW-1:0] lock_loss_count;
  logic [CW-1:0] retry_count;
  logic [2:0]    state_dbg;

  hps_design_pll_reset_seq #(
    .NUM_STAGES          (NS),
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC),
    .STAGE_GAP_CYCLES    (GAP),
    .CNT_W               (CW)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .rst_out         (rst_out),
    .ready           (ready),
    .lock_loss_count (lock_loss_count),
    .retry_count     (retry_count),
    .state_dbg       (state_dbg)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: phase, edge index at which it was entered, number of released stages.
  int m_cyc = 0;
  int m_enter = 0;
  int m_mode = MPllReset;
  int m_cleared = 0;
  int m_loss = 0;
  int m_retry = 0;
  bit m_s1 = 1'b0;
  bit m_s2 = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < CntMax) ? v + 1 : v;
  endfunction

  task automatic enter(input int mode);
    m_mode  = mode;
    m_enter = m_cyc;
  endtask

  // Advance the model by one rising edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit lk;
    int n;
    m_cyc++;
    if (rst) begin
      enter(MPllReset);
      m_cleared = 0;
      m_loss    = 0;
      m_retry   = 0;
      m_s1      = 1'b0;
      m_s2      = 1'b0;
      return;
    end
    lk   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    n    = m_cyc - m_enter;
    case (m_mode)
      MPllReset: if (n == PRC) enter(MWaitLock);
      MWaitLock: begin
        if (lk) enter(MLockQual);
        else if (n == LTC) begin
          enter(MPllReset);
          m_retry = sat(m_retry);
        end
      end
      MLockQual: begin
        if (!lk) enter(MWaitLock);
        else if (n == LSC) begin
          enter(MRelease);
          m_cleared = 1;
        end
      end
      default: begin  // release or run
        if (!lk) begin
          enter(MWaitLock);
          m_cleared = 0;
          m_loss    = sat(m_loss);
        end else if (m_mode == MRelease) begin
          if (m_cleared == NS) enter(MRun);
          else if (n % GAP == 0) m_cleared++;
        end
      end
    endcase
  endtask

  function automatic logic [NS-1:0] exp_rst_out();
    return NS'(((1 << NS) - 1) & ~((1 << m_cleared) - 1));
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_step();
    #1;
    check_eq("pll_rst", 32'(pll_rst), 32'(m_mode == MPllReset));
    check_eq("rst_out", 32'(rst_out), 32'(exp_rst_out()));
    check_eq("ready", 32'(ready), 32'(m_mode == MRun));
    check_eq("state_dbg", 32'(state_dbg), 32'(m_mode));
    check_eq("lock_loss_count", 32'(lock_loss_count), 32'(m_loss));
    check_eq("retry_count", 32'(retry_count), 32'(m_retry));
  endtask

  function automatic bit dut_cond(input int sel);
    case (sel)
      0:       return rst_out[0] == 1'b0;
      1:       return rst_out[1] == 1'b0;
      2:       return rst_out[2] == 1'b0;
      3:       return ready == 1'b1;
      default: return rst_out == 3'b110;
    endcase
  endfunction

  task automatic wait_cond(input string tag, input int sel, input int budget, output int edges);
    int n;
    bit hit;
    n   = 0;
    hit = dut_cond(sel);
    while (!hit && n < budget) begin
      tick();
      n++;
      hit = dut_cond(sel);
    end
    edges = n;
    check_eq({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int e;
    int pll_hi;
    int last_rise;
    bit prev_pr;
    int hold;

    // 1. Normal bring-up
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    pll_hi = int'(pll_rst);
    for (int i = 1; i < 10; i++) begin
      tick();
      pll_hi += int'(pll_rst);
    end
    check_eq("pll_rst_width", 32'(pll_hi), 32'(PRC));
    tick();
    pll_locked = 1'b1;
    // Two synchroniser edges, one edge into qualification, LSC qualifying edges.
    wait_cond("rst0_fall", 0, 60, e);
    check_eq("rst0_latency", 32'(e), 32'(2 + 1 + LSC));
    wait_cond("rst1_fall", 1, 20, e);
    check_eq("rst1_gap", 32'(e), 32'(GAP));
    wait_cond("rst2_fall", 2, 20, e);
    check_eq("rst2_gap", 32'(e), 32'(GAP));
    wait_cond("ready_rise", 3, 20, e);
    check_eq("ready_latency", 32'(e), 32'd1);

    // 2. Lock never achieved
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    last_rise = -1;
    prev_pr = 1'b1;
    for (int i = 0; i < 5 * (PRC + LTC) + 10; i++) begin
      tick();
      if (pll_rst && !prev_pr) begin
        if (last_rise >= 0) check_eq("retry_period", 32'(i - last_rise), 32'(PRC + LTC));
        last_rise = i;
      end
      prev_pr = pll_rst;
    end
    check_eq("retry_saturated", 32'(retry_count), 32'(CntMax));

    // 3. Lock glitch at qualification count 5
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    pll_locked = 1'b1;
    for (int i = 0; i < 100 && !(m_mode == MLockQual && m_cyc - m_enter == 5); i++) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_cond("glitch_rst0_fall", 0, 60, e);
    check_eq("glitch_requal", 32'(e), 32'(2 + 1 + LSC));
    wait_cond("glitch_ready", 3, 30, e);
    check_eq("glitch_loss_cnt", 32'(lock_loss_count), 32'd0);
    check_eq("glitch_retry_cnt", 32'(retry_count), 32'd0);

    // 4. Loss in RUN
    pll_locked = 1'b0;
    repeat (2) tick();
    check_eq("run_loss_ready_hold", 32'(ready), 32'd1);
    tick();
    check_eq("run_loss_rst_out", 32'(rst_out), 32'h7);
    check_eq("run_loss_ready", 32'(ready), 32'd0);
    check_eq("run_loss_count", 32'(lock_loss_count), 32'd1);
    check_eq("run_loss_pll_rst", 32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    wait_cond("rerelease_ready", 3, 60, e);

    // 5. Repeated loss mid-RELEASE
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    pll_locked = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_cond("rel_partial", 4, 80, e);
      repeat ($urandom_range(0, 2)) tick();
      pll_locked = 1'b0;
      repeat (3 + $urandom_range(0, 3)) tick();
      check_eq("rel_loss_rst_out", 32'(rst_out), 32'h7);
      pll_locked = 1'b1;
    end
    check_eq("rel_loss_saturated", 32'(lock_loss_count), 32'(CntMax));

    // 6. Reset mid-RELEASE with rst_out=110
    wait_cond("rst_mid_partial", 4, 80, e);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("rst_mid_rst_out", 32'(rst_out), 32'h7);
    check_eq("rst_mid_loss", 32'(lock_loss_count), 32'd0);
    check_eq("rst_mid_retry", 32'(retry_count), 32'd0);
    check_eq("rst_mid_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // Random lock activity with occasional resets
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 45);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
